// File: rtl/window_weight_buffer.sv
// Fmap / weight-set / bias byte store feeding the PE array: KSIZE-lane writes, one-cycle windowed reads.
// Define WRITE_BYPASS_EN to forward same-cycle write data into an accepted read bundle.
module window_weight_buffer #(
    parameter int WIDTH     = 80,
    parameter int HEIGHT    = 8,
    parameter int KSIZE     = 9,
    parameter int NSETS     = 6,
    parameter int BIAS_COLS = 2,
    parameter int W_B       = 7,
    parameter int H_B       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W_B-1:0]               wr_w,
    input  logic [H_B-1:0]               wr_h,
    input  logic [8*KSIZE-1:0]           wr_data,
    input  logic [KSIZE-1:0]             wr_en,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [W_B*KSIZE-1:0]         rd_w,
    input  logic [H_B*KSIZE-1:0]         rd_h,
    input  logic [2:0]                   step,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*KSIZE-1:0]           fmap,
    output logic [8*KSIZE*HEIGHT-1:0]    weight,
    output logic [16*HEIGHT-1:0]         biases,
    output logic                         err_oob
);

    localparam int COLS = WIDTH + BIAS_COLS;

    logic [7:0]                  mem_r [COLS][HEIGHT];
    logic [W_B:0]                lane_col_s [KSIZE];
    logic [KSIZE-1:0]            lane_ok_s;
    logic                        oob_s;
    logic                        accept_s;
    logic                        out_valid_r;
    logic                        err_oob_r;
    logic [8*KSIZE-1:0]          fmap_r;
    logic [8*KSIZE*HEIGHT-1:0]   weight_r;
    logic [16*HEIGHT-1:0]        biases_r;
    logic [8*KSIZE-1:0]          fmap_s;
    logic [8*KSIZE*HEIGHT-1:0]   weight_s;
    logic [16*HEIGHT-1:0]        biases_s;

    // One array byte, zero outside the array; optionally overridden by a same-cycle write
    function automatic logic [7:0] fetch(input int c, input int r);
        logic [7:0] b;
        b = 8'h00;
        if ((c < COLS) && (r < HEIGHT)) begin
            b = mem_r[W_B'(c)][H_B'(r)];
`ifdef WRITE_BYPASS_EN
            for (int k = 0; k < KSIZE; k++) begin
                if (wr_en[k] && lane_ok_s[k] && (int'(lane_col_s[k]) == c) && (int'(wr_h) == r)) begin
                    b = wr_data[8*k +: 8];
                end else begin
                    b = b;
                end
            end
`endif
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

    assign rd_ready  = !out_valid_r || out_ready;
    assign accept_s  = rd_valid && rd_ready;
    assign out_valid = out_valid_r;
    assign fmap      = fmap_r;
    assign weight    = weight_r;
    assign biases    = biases_r;
    assign err_oob   = err_oob_r;

    // Write-lane column decode; the extra column bit keeps base+offset from wrapping
    always_comb begin
        lane_ok_s = '0;
        oob_s     = 1'b0;
        for (int k = 0; k < KSIZE; k++) begin
            lane_col_s[k] = {1'b0, wr_w} + (W_B+1)'(KSIZE - 1 - k);
            lane_ok_s[k]  = (int'(lane_col_s[k]) < COLS) && (int'(wr_h) < HEIGHT);
            oob_s         = oob_s | (wr_en[k] & ~lane_ok_s[k]);
        end
    end

    // Next bundle: fmap window, selected weight set for every row, all biases
    always_comb begin
        int set_i;
        int base_i;
        int c_i;
        int r_i;
        fmap_s   = '0;
        weight_s = '0;
        biases_s = '0;
        set_i    = (int'(step) < NSETS) ? int'(step) : 0;
        base_i   = WIDTH - KSIZE * (set_i + 1);
        for (int i = 0; i < KSIZE; i++) begin
            c_i = int'(rd_w[W_B*(KSIZE-1-i) +: W_B]);
            r_i = int'(rd_h[H_B*(KSIZE-1-i) +: H_B]);
            fmap_s[8*(KSIZE-1-i) +: 8] = fetch(c_i, r_i);
        end
        for (int r = 0; r < HEIGHT; r++) begin
            for (int j = 0; j < KSIZE; j++) begin
                weight_s[8*KSIZE*(HEIGHT-1-r) + 8*(KSIZE-1-j) +: 8] = fetch(base_i + j, r);
            end
            biases_s[16*(HEIGHT-1-r) +: 16] = {fetch(WIDTH, r), fetch(WIDTH + 1, r)};
        end
    end

    // Storage write port; contents are deliberately left out of reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < KSIZE; k++) begin
            if (!rst && wr_en[k] && lane_ok_s[k]) begin
                mem_r[lane_col_s[k][W_B-1:0]][wr_h] <= wr_data[8*k +: 8];
            end
        end
    end

    // Output bundle register with valid/ready hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            fmap_r      <= '0;
            weight_r    <= '0;
            biases_r    <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            fmap_r      <= fmap_s;
            weight_r    <= weight_s;
            biases_r    <= biases_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky out-of-bounds write flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob_r <= 1'b0;
        end else if (oob_s) begin
            err_oob_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_window_weight_buffer.sv
// Self-checking bench for window_weight_buffer: directed scenarios plus randomized traffic vs a behavioural model.
module tb_window_weight_buffer;

    localparam int WIDTH  = 80;
    localparam int HEIGHT = 8;
    localparam int KSIZE  = 9;
    localparam int NSETS  = 6;
    localparam int W_B    = 7;
    localparam int H_B    = 3;
    localparam int COLS   = WIDTH + 2;
`ifdef WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rst;
    logic [W_B-1:0]              wr_w;
    logic [H_B-1:0]              wr_h;
    logic [8*KSIZE-1:0]          wr_data;
    logic [KSIZE-1:0]            wr_en;
    logic                        rd_valid;
    logic                        rd_ready;
    logic [W_B*KSIZE-1:0]        rd_w;
    logic [H_B*KSIZE-1:0]        rd_h;
    logic [2:0]                  step;
    logic                        out_valid;
    logic                        out_ready;
    logic [8*KSIZE-1:0]          fmap;
    logic [8*KSIZE*HEIGHT-1:0]   weight;
    logic [16*HEIGHT-1:0]        biases;
    logic                        err_oob;

    window_weight_buffer dut (
        .clk(clk), .rst(rst), .wr_w(wr_w), .wr_h(wr_h), .wr_data(wr_data), .wr_en(wr_en),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_w(rd_w), .rd_h(rd_h), .step(step),
        .out_valid(out_valid), .out_ready(out_ready), .fmap(fmap), .weight(weight),
        .biases(biases), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    // Model state: array image plus the bundle the DUT should currently present
    logic [7:0]                  mm [128][8];
    logic                        e_valid, e_err, e_zero;
    logic [8*KSIZE-1:0]          e_fmap;
    logic [8*KSIZE*HEIGHT-1:0]   e_weight;
    logic [16*HEIGHT-1:0]        e_bias;
    bit                          chk_en = 1'b0;
    int                          tests = 0;
    int                          fails = 0;

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lane_col(input int k);
        return int'(wr_w) + KSIZE - 1 - k;
    endfunction

    function automatic bit lane_ok(input int k);
        return (lane_col(k) < COLS) && (int'(wr_h) < HEIGHT);
    endfunction

    // Value a read of (c,r) must see this cycle: old contents, or new write data when bypassing
    function automatic logic [7:0] view(input int c, input int r);
        logic [7:0] v;
        logic [8*KSIZE-1:0] dw;
        if (c >= COLS || r >= HEIGHT) return 8'h00;
        v  = mm[c][r];
        dw = wr_data;
        for (int k = 0; k < KSIZE; k++) begin
            if (BYP && wr_en[k] && lane_ok(k) && lane_col(k) == c && int'(wr_h) == r) v = dw[7:0];
            dw = dw >> 8;
        end
        return v;
    endfunction

    function automatic logic [8*KSIZE-1:0] m_fmap();
        logic [8*KSIZE-1:0] f;
        logic [W_B*KSIZE-1:0] aw;
        logic [H_B*KSIZE-1:0] ah;
        f = '0; aw = rd_w; ah = rd_h;
        for (int i = 0; i < KSIZE; i++) begin
            f  = {f[8*KSIZE-9:0], view(int'(aw[W_B*KSIZE-1 -: W_B]), int'(ah[H_B*KSIZE-1 -: H_B]))};
            aw = aw << W_B;
            ah = ah << H_B;
        end
        return f;
    endfunction

    function automatic logic [8*KSIZE*HEIGHT-1:0] m_weight();
        logic [8*KSIZE*HEIGHT-1:0] w;
        int s;
        w = '0;
        s = (int'(step) < NSETS) ? int'(step) : 0;
        for (int r = 0; r < HEIGHT; r++)
            for (int j = 0; j < KSIZE; j++)
                w = {w[8*KSIZE*HEIGHT-9:0], view(WIDTH - KSIZE * (s + 1) + j, r)};
        return w;
    endfunction

    function automatic logic [16*HEIGHT-1:0] m_bias();
        logic [16*HEIGHT-1:0] b;
        b = '0;
        for (int r = 0; r < HEIGHT; r++) b = {b[16*HEIGHT-17:0], view(WIDTH, r), view(WIDTH + 1, r)};
        return b;
    endfunction

    function automatic bit m_drop();
        bit d;
        d = 1'b0;
        for (int k = 0; k < KSIZE; k++) if (wr_en[k] && !lane_ok(k)) d = 1'b1;
        return d;
    endfunction

    // Behavioural model advanced at each active edge
    always @(posedge clk) begin
        if (rst) begin
            e_valid  <= 1'b0;
            e_err    <= 1'b0;
            e_zero   <= 1'b1;
            e_fmap   <= '0;
            e_weight <= '0;
            e_bias   <= '0;
        end else begin
            if (rd_valid && (!e_valid || out_ready)) begin
                e_valid  <= 1'b1;
                e_zero   <= 1'b0;
                e_fmap   <= m_fmap();
                e_weight <= m_weight();
                e_bias   <= m_bias();
            end else if (out_ready) begin
                e_valid <= 1'b0;
            end
            if (m_drop()) e_err <= 1'b1;
            for (int k = 0; k < KSIZE; k++)
                if (wr_en[k] && lane_ok(k)) mm[W_B'(lane_col(k))][wr_h] <= wr_data[8*k +: 8];
        end
    end

    // Compare process on the inactive edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, e_valid);
            check("rd_ready", rd_ready, !e_valid || out_ready);
            check("err_oob", err_oob, e_err);
            if (e_valid || e_zero) begin
                check("fmap", fmap, e_fmap);
                check("weight", weight, e_weight);
                check("biases", biases, e_bias);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_line(input int c0, input int r);
        rd_w = '0;
        rd_h = '0;
        for (int i = 0; i < KSIZE; i++) begin
            rd_w = {rd_w[W_B*(KSIZE-1)-1:0], W_B'(c0 + i)};
            rd_h = {rd_h[H_B*(KSIZE-1)-1:0], H_B'(r)};
        end
    endtask

    task automatic rand_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        wr_data = t[8*KSIZE-1:0];
    endtask

    initial begin
        logic [8*KSIZE-1:0]        snap;
        logic [8*KSIZE*HEIGHT-1:0] ew;
        rst = 1'b1; wr_w = '0; wr_h = '0; wr_data = '0; wr_en = '0;
        rd_valid = 1'b0; rd_w = '0; rd_h = '0; step = 3'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_err_oob", err_oob, 1'b0);
        check("reset_fmap", fmap, 72'h0);

        // Fill the whole array with random bytes
        for (int r = 0; r < HEIGHT; r++) begin
            for (int b = 0; b <= 9; b++) begin
                wr_w = (b == 9) ? 7'd73 : W_B'(9 * b);
                wr_h = H_B'(r); wr_en = 9'h1FF; rand_data();
                tick();
            end
        end
        wr_en = '0;

        // Basic window read
        wr_w = 7'd0; wr_h = 3'd2; wr_data = 72'h010203040506070809; wr_en = 9'h1FF;
        tick();
        wr_en = '0; rd_valid = 1'b1; rd_line(0, 2);
        tick();
        rd_valid = 1'b0;
        check("basic_valid", out_valid, 1'b1);
        check("basic_fmap", fmap, 72'h010203040506070809);

        // Weight sets 3 and 0
        for (int r = 0; r < HEIGHT; r++) begin
            wr_h = H_B'(r); wr_en = 9'h1FF;
            wr_w = 7'd44; wr_data = {KSIZE{8'h30 + 8'(r)}}; tick();
            wr_w = 7'd71; wr_data = {KSIZE{8'h70 + 8'(r)}}; tick();
        end
        wr_en = '0; rd_valid = 1'b1; rd_line(0, 0); step = 3'd3;
        tick();
        ew = '0;
        for (int r = 0; r < HEIGHT; r++) ew = {ew[8*KSIZE*HEIGHT-73:0], {KSIZE{8'h30 + 8'(r)}}};
        check("set3_weight", weight, ew);
        step = 3'd7;
        tick();
        rd_valid = 1'b0;
        ew = '0;
        for (int r = 0; r < HEIGHT; r++) ew = {ew[8*KSIZE*HEIGHT-73:0], {KSIZE{8'h70 + 8'(r)}}};
        check("step7_weight", weight, ew);

        // Bias bytes and zero padding
        wr_w = 7'd73; wr_h = 3'd5; wr_en = 9'h003; wr_data = {56'h0, 8'hAB, 8'hCD};
        tick();
        wr_en = '0; rd_valid = 1'b1; rd_line(0, 0);
        rd_w[W_B*4 +: W_B] = 7'd100; rd_h[H_B*4 +: H_B] = 3'd7;
        tick();
        rd_valid = 1'b0;
        check("bias_row5", biases[16*2 +: 16], 16'hABCD);
        check("pad_elem4", fmap[8*4 +: 8], 8'h00);

        // Backpressure: hold five cycles, then back-to-back release
        tick();
        out_ready = 1'b0; rd_valid = 1'b1; rd_line(10, 3);
        tick();
        snap = fmap;
        rd_line(20, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rd_ready", rd_ready, 1'b0);
            check("bp_stable", fmap, snap);
        end
        out_ready = 1'b1;
        #1;
        check("release_rd_ready", rd_ready, 1'b1);
        tick();
        rd_valid = 1'b0;
        check("release_valid", out_valid, 1'b1);

        // Same-cycle write and read of one entry
        wr_w = 7'd3; wr_h = 3'd1; wr_en = 9'h100; wr_data = {8'h11, 64'h0};
        tick();
        wr_data = {8'hEE, 64'h0}; rd_valid = 1'b1; rd_line(0, 1);
        for (int i = 0; i < KSIZE; i++) rd_w[W_B*i +: W_B] = 7'd3;
        tick();
        wr_en = '0; rd_valid = 1'b0;
        check("rw_collision", fmap[8*8 +: 8], BYP ? 8'hEE : 8'h11);

        // Partly out-of-bounds write, then reset with a bundle held
        wr_w = 7'd78; wr_h = 3'd6; wr_en = 9'h1FF; rand_data();
        tick();
        wr_en = '0;
        check("oob_flag", err_oob, 1'b1);
        out_ready = 1'b0; rd_valid = 1'b1; rd_line(76, 6);
        tick();
        rd_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_err", err_oob, 1'b0);
        check("rst_fmap", fmap, 72'h0);
        check("rst_weight", weight, 576'h0);
        check("rst_bias", biases, 128'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 149) == 0);
            rd_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            step      = 3'($urandom_range(0, 7));
            for (int i = 0; i < KSIZE; i++) begin
                rd_w[W_B*i +: W_B] = W_B'($urandom_range(0, 90));
                rd_h[H_B*i +: H_B] = H_B'($urandom_range(0, 7));
            end
            wr_en = ($urandom_range(0, 1) == 0) ? 9'h000 : 9'($urandom_range(0, 511));
            wr_w  = W_B'($urandom_range(0, 85));
            wr_h  = H_B'($urandom_range(0, 7));
            rand_data();
            tick();
        end
        rst = 1'b0; wr_en = '0; rd_valid = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_weight_buffer.md
Name: window_weight_buffer

Overview:
Parametrised successor of the on-chip fmap/weight/bias store feeding the PE array. One 2-D byte array holds the fmap region, NSETS kernel-weight sets and per-row 16-bit biases. Each accepted read request returns, one cycle later, a KSIZE-element fmap window, the selected weight set for all ROWS output channels, and all biases. Reads use a valid/ready handshake with output backpressure. Writes are KSIZE-lane with per-lane enables and bounds checking.

Parameters:
WIDTH, 80, total fmap+weight columns (bias columns excluded)
HEIGHT, 8, rows; also the number of output channels (ROWS = HEIGHT)
KSIZE, 9, window/kernel element count
NSETS, 6, number of weight sets
BIAS_COLS, 2, bias columns above WIDTH; fixed at 2 (hi byte, lo byte)
W_B, 7, column address width; 2^W_B >= WIDTH+BIAS_COLS required
H_B, 3, row address width; 2^H_B >= HEIGHT required

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_w  in  W_B  write base column
wr_h  in  H_B  write row
wr_data  in  8*KSIZE  write bytes, lane KSIZE-1 in MSBs
wr_en  in  KSIZE  per-lane write enable
rd_valid  in  1  read request valid
rd_ready  out  1  read request accepted when rd_valid and rd_ready are both 1
rd_w  in  W_B*KSIZE  window column addresses, element 0 in MSBs
rd_h  in  H_B*KSIZE  window row addresses, element 0 in MSBs
step  in  3  weight-set select, sampled on accept
out_valid  out  1  output bundle valid
out_ready  in  1  consumer ready
fmap  out  8*KSIZE  window bytes, element 0 in MSBs
weight  out  8*KSIZE*HEIGHT  row 0 in MSBs; within a row, set column +0 in MSBs
biases  out  16*HEIGHT  row 0 in MSBs; each entry is {mem[WIDTH][r], mem[WIDTH+1][r]}
err_oob  out  1  sticky out-of-bounds write flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Storage: mem[0..WIDTH+BIAS_COLS-1][0..HEIGHT-1], 8 bits per entry. Contents are not reset.
- Weight set s occupies columns WIDTH-KSIZE*(s+1) .. WIDTH-KSIZE*(s+1)+KSIZE-1.
- Weight-set select: step >= NSETS selects set 0.
- Fmap region: columns 0 .. WIDTH-KSIZE*NSETS-1. This region is a convention only; reads may address any column.
- Reset: out_valid=0, fmap/weight/biases=0, err_oob=0. An in-flight bundle is discarded. Writes during a reset cycle are ignored.
- Handshake:
  - rd_ready = !out_valid || out_ready (combinational).
  - On accept, output registers load and out_valid=1 on the next edge. Latency is 1 cycle.
  - While out_valid && !out_ready, all outputs hold stable and rd_ready=0.
  - If out_valid && out_ready && rd_valid in the same cycle, the next bundle loads back-to-back at full throughput.
  - If out_ready=1 with no new accept, out_valid clears.
- Zero padding: a window element whose rd_w >= WIDTH+BIAS_COLS or rd_h >= HEIGHT returns 0x00.
- Write lanes:
  - Lane k (wr_en[k]) writes wr_data[8k+7:8k] to column wr_w+(KSIZE-1-k), row wr_h. Column arithmetic is W_B+1 bits wide, with no wrap.
  - A lane with column >= WIDTH+BIAS_COLS, or any lane when wr_h >= HEIGHT, is dropped and sets err_oob. Other lanes still write.
  - err_oob clears only on rst.
- Same-cycle write and read accept to the same entry: the read returns the pre-write value. The optional feature changes this.
- Writes may target the weight or bias columns at any time. A bundle already in the output register is unaffected.

Optional Feature:
WRITE_BYPASS_EN
- Defined: on a same-cycle write and accept, any fmap, weight or bias byte whose entry is being written returns the new wr_data byte (per-lane forwarding).
- Undefined: read-before-write semantics as stated above. No forwarding logic is built.

Test Plan:
- Write wr_w=0, wr_h=2, wr_data=0x01..0x09, wr_en=0x1FF. Then read rd_w={0..8}, rd_h=all 2 -> one cycle after accept, out_valid=1 and fmap=0x010203040506070809.
- Load set 3 at columns 44..52 with row r = 0x30+r. Read with step=3 -> each weight row r is nine bytes of 0x30+r. Repeat with step=7 -> the set-0 contents at columns 71..79 are returned.
- Write mem[80][5]=0xAB and mem[81][5]=0xCD. Read -> biases row 5 = 0xABCD. Read with element 4 at rd_h=7, rd_w=100 -> fmap element 4 = 0x00.
- Hold out_ready=0 for 5 cycles with rd_valid=1 -> rd_ready=0 and outputs stable throughout. Then assert out_ready=1 -> the next bundle appears the following cycle with no gap.
- Write 0xEE to entry (3,1) in the same cycle as a read accept at (3,1), where the old value is 0x11 -> fmap=0x11 without the macro, 0xEE with WRITE_BYPASS_EN.
- Write wr_w=78, wr_en=0x1FF -> columns 78..81 are written, the other 5 lanes are dropped, and err_oob=1. Assert rst with out_valid=1 -> out_valid=0, err_oob=0, outputs zero on the next cycle.
